aes_kexp_seq: RTL

AES_KEXP_SEQ -- requirements
Module: aes_kexp_seq

---
 rtl/aes_kexp_seq.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/aes_kexp_seq.sv
// aes_const / aes_sbox4 / aes_kexp_seq
//
// Purpose: sequential AES key expansion. An accepted cipher key is turned into
// the full round-key schedule one word per clock. The whole schedule is then
// presented in parallel on KExp.
//
// Build size: Nb, Nk and Nr come from package aes_const.
//   Nk=4 gives AES-128, Nk=6 gives AES-192, Nk=8 gives AES-256.
//   Nr is derived from Nk.
//
// Ports (aes_kexp_seq):
//   clock       in   single clock, all state updates on the rising edge
//   reset       in   synchronous active-low reset
//   Key_in      in   4*Nk key bytes; Key_in[0] is the most significant byte of W[0]
//   key_valid   in   Key_in is valid this cycle
//   key_ready   out  a key is accepted this cycle (IDLE or DONE)
//   KExp        out  expanded words W[0..Nb*(Nr+1)-1], straight from registers
//   kexp_valid  out  KExp holds the complete schedule of the last accepted key

package aes_const;
  localparam int Nb = 4;
  localparam int Nk = 4;
  localparam int Nr = Nk + 6;
endpackage

// Four parallel FIPS-197 S-box lookups on a 32-bit word.
module aes_sbox4 (
  input  logic [31:0] word_in,
  output logic [31:0] word_out
);
  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  for (genvar b = 0; b < 4; b++) begin : g_byte
    assign word_out[8*b +: 8] = SBOX[word_in[8*b +: 8]];
  end
endmodule

module aes_kexp_seq
  import aes_const::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  Key_in [0:4*Nk-1],
  input  logic        key_valid,
  output logic        key_ready,
  output logic [31:0] KExp [0:Nb*(Nr+1)-1],
  output logic        kexp_valid
);
  localparam int NW = Nb * (Nr + 1);
  localparam int IW = $clog2(NW);
  localparam int PW = $clog2(Nk);
  localparam bit SUB_MID = (Nk > 6);

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  state_t        state_q, state_d;
  logic [31:0]   w_q [0:NW-1];
  logic [31:0]   w_d [0:NW-1];
  logic [IW-1:0] idx_q, idx_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [7:0]    rcon_q, rcon_d;

  logic [31:0] prev_word, old_word, sbox_in, sbox_out, temp;
  logic        accept;

  assign accept = key_valid && (state_q != EXPAND);

  // Only W[i-1] and W[i-Nk] feed the datapath.
  assign prev_word = w_q[idx_q - IW'(1)];
  assign old_word  = w_q[idx_q - IW'(Nk)];

  // phase_q tracks i mod Nk, which avoids a divider for AES-192.
  // RotWord is applied only on the round-constant step.
  assign sbox_in = (phase_q == '0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;

  aes_sbox4 u_sbox (
    .word_in  (sbox_in),
    .word_out (sbox_out)
  );

  always_comb begin
    temp = prev_word;
    if (phase_q == '0) begin
      temp = sbox_out ^ {rcon_q, 24'h0};
    end else if (SUB_MID && (int'(phase_q) == 4)) begin
      temp = sbox_out;
    end
  end

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    idx_d   = idx_q;
    phase_d = phase_q;
    rcon_d  = rcon_q;
    if (accept) begin
      w_d = '{default: 32'h0};
      for (int j = 0; j < Nk; j++) begin
        w_d[j] = {Key_in[4*j], Key_in[4*j+1], Key_in[4*j+2], Key_in[4*j+3]};
      end
      idx_d   = IW'(Nk);
      phase_d = '0;
      rcon_d  = 8'h01;
      state_d = EXPAND;
    end else if (state_q == EXPAND) begin
      w_d[idx_q] = old_word ^ temp;
      idx_d      = idx_q + IW'(1);
      phase_d    = (phase_q == PW'(Nk - 1)) ? '0 : phase_q + PW'(1);
      // xtime: a left shift reduced by the AES polynomial when bit 7 falls out.
      if (phase_q == '0) begin
        rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
      end
      // The index stops at the last word so that it cannot wrap.
      if (idx_q == IW'(NW - 1)) begin
        idx_d   = idx_q;
        state_d = DONE;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      w_q     <= '{default: 32'h0};
      idx_q   <= '0;
      phase_q <= '0;
      rcon_q  <= 8'h01;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      idx_q   <= idx_d;
      phase_q <= phase_d;
      rcon_q  <= rcon_d;
    end
  end

  assign KExp       = w_q;
  assign key_ready  = (state_q != EXPAND);
  assign kexp_valid = (state_q == DONE);
endmodule
